beat_tick_gen: RTL
==================

// Module: beat_tick_gen
// PURPOSE
//   Upstream timing stage for the 8-bit note/beat counter. Divides the system
//   clock into one-cycle tick pulses that drive that counter's enable, at a
//   programmable period. Tracks beat position within a bar and supports
//   start/pause/stop control. A tempo change takes effect only at a period
//   boundary.
// PARAMETERS
//   DIV_WIDTH      26          width of divider and period registers
//   DEFAULT_PERIOD 12_500_000  reset period in clocks (50 MHz / 4 = 250 ms)
//   BEATS_PER_BAR  4           beats per bar, >=2; beat_idx wraps at this value
// PORTS
//   clock        in   1          system clock, rising edge
//   reset_n      in   1          synchronous, active-low reset
//   start        in   1          IDLE->RUN or PAUSE->RUN (level sampled each cycle)
//   pause        in   1          RUN->PAUSE
//   stop         in   1          any state->IDLE
//   period_in    in   DIV_WIDTH  requested period, in clocks
//   period_load  in   1          one-cycle strobe that captures period_in
//   tick         out  1          one-cycle pulse per period; feeds counter enable
//   beat_idx     out  clog2(BPB) index of the beat announced by the current/last tick
//   downbeat     out  1          high together with a tick whose beat_idx == 0
//   running      out  1          high in RUN
//   period_ack   out  1          one-cycle pulse, the cycle after period_load
// BEHAVIOUR
//   - Reset (reset_n=0 at clock edge): state=IDLE; tick, downbeat, running,
//     period_ack = 0; beat_idx = 0; next_beat = 0; divider = 0;
//     active_period = pending_period = DEFAULT_PERIOD.
//   - All outputs are registered.
//   - Control priority, evaluated each cycle: stop > pause > start.
//   - FSM:
//     IDLE --start--> RUN: divider <= active_period-1; next_beat <= 0.
//     RUN --pause--> PAUSE: divider frozen; no ticks.
//     PAUSE --start--> RUN: countdown resumes from the frozen value.
//     any --stop--> IDLE: divider, beat_idx and next_beat cleared; no tick.
//     start while already in RUN, or pause while in IDLE/PAUSE: ignored.
//   - Countdown in RUN, when divider == 0:
//     tick <= 1; beat_idx <= next_beat; downbeat <= (next_beat == 0);
//     next_beat <= (next_beat == BPB-1) ? 0 : next_beat+1;
//     active_period <= pending_period; divider <= pending_period-1.
//     Otherwise divider decrements and tick/downbeat <= 0.
//   - Latency: the first tick occurs exactly P clock edges after the start
//     edge (P = active_period). Tick spacing is exactly P cycles.
//   - period_load (any state): pending_period <= max(period_in, 2), so a tick
//     never fires on consecutive cycles. period_ack <= 1 next cycle.
//     If period_load coincides with a reload, the new value is used for that
//     reload. A load in IDLE is applied at the next start.
//   - Pause on the same cycle the divider reaches 0: pause wins; no tick;
//     divider stays 0; the tick fires on the first RUN cycle after resume.
//   - Stop on the tick cycle: no tick is emitted.
//   - Reset mid-RUN: all state returns to reset values at that edge; the
//     loaded period is lost.
// STRUCTURE
//   - Shared include timing_defs.vh: FSM state encodings (IDLE=2'd0, RUN=2'd1,
//     PAUSE=2'd2) and the DEFAULT_PERIOD / clock-rate constants, reused by
//     the note scroller.
//   - One sub-module, rate_divider: loadable down-counter with enable and
//     terminal-count output. The FSM, beat tracking and period handshake stay
//     in the top level.
// TESTING (override DEFAULT_PERIOD=4, BEATS_PER_BAR=4)
//   1. Reset, then start pulse at cycle 0 -> ticks at cycles 4, 8, 12, 16.
//      beat_idx = 0,1,2,3; downbeat only at cycle 4; running=1 from cycle 1.
//   2. Run to cycle 20 -> 5th tick has beat_idx=0 and downbeat=1 (wrap).
//   3. period_in=6 with period_load at cycle 5 -> period_ack at cycle 6; tick
//      at cycle 8 (old period), then at 14 and 20.
//   4. period_in=1 loaded -> clamped to 2; ticks every 2 cycles, never on
//      adjacent cycles.
//   5. Pause at cycle 6, start at cycle 10 -> no ticks in 6..10; next tick at
//      cycle 12 (2 remaining counts preserved); pause on a tick cycle
//      suppresses that tick.
//   6. stop and start high together in RUN -> IDLE, no tick; reset_n low mid-RUN
//      -> all outputs 0 next edge, period back to 4.

Source files
------------

// File: rtl/beat_tick_gen_pkg.sv
// Shared timing definitions for the beat tick generator and the note scroller.
//   state_t             : FSM state encodings (IDLE/RUN/PAUSE)
//   CLOCK_HZ            : system clock rate
//   DEFAULT_PERIOD_CLKS : reset tick period (250 ms at 50 MHz)
//   MIN_PERIOD          : smallest accepted period; keeps ticks non-adjacent
package beat_tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned CLOCK_HZ            = 50_000_000;
  localparam int unsigned TICKS_PER_SEC       = 4;
  localparam int unsigned DEFAULT_PERIOD_CLKS = CLOCK_HZ / TICKS_PER_SEC;
  localparam int unsigned MIN_PERIOD          = 2;

endpackage

// File: rtl/beat_tick_gen_rate_divider.sv
// rate_divider: loadable down-counter with enable and terminal-count flag.
//   clock      in  system clock, rising edge
//   reset_n    in  synchronous active-low reset (count -> 0)
//   clear      in  synchronous clear (count -> 0), highest priority after reset
//   load       in  load load_value into the counter
//   load_value in  WIDTH-bit reload value
//   enable     in  decrement by one when not loading
//   tc         out high while the count is zero
module rate_divider #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/beat_tick_gen.sv
// beat_tick_gen: divides the system clock into one-cycle tick pulses at a
// programmable period, tracks beat position within a bar and provides
// start/pause/stop control. Tempo changes apply only at period boundaries.
//   clock       in  system clock, rising edge
//   reset_n     in  synchronous active-low reset
//   start       in  IDLE->RUN or PAUSE->RUN (level)
//   pause       in  RUN->PAUSE
//   stop        in  any state->IDLE (highest priority)
//   period_in   in  requested period in clocks
//   period_load in  strobe capturing period_in (clamped to >= 2)
//   tick        out one-cycle pulse per period
//   beat_idx    out beat announced by the current/last tick
//   downbeat    out high with a tick whose beat_idx is 0
//   running     out high in RUN
//   period_ack  out one-cycle pulse following period_load
module beat_tick_gen
  import beat_tick_gen_pkg::*;
#(
  parameter int unsigned DIV_WIDTH      = 26,
  parameter int unsigned DEFAULT_PERIOD = DEFAULT_PERIOD_CLKS,
  parameter int unsigned BEATS_PER_BAR  = 4,
  localparam int unsigned BEAT_W        = $clog2(BEATS_PER_BAR)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] period_in,
  input  logic                 period_load,
  output logic                 tick,
  output logic [BEAT_W-1:0]    beat_idx,
  output logic                 downbeat,
  output logic                 running,
  output logic                 period_ack
);

  state_t                state, next_state;
  logic [DIV_WIDTH-1:0]  active_period, pending_period;
  logic [DIV_WIDTH-1:0]  load_clamped, pending_eff;
  logic [BEAT_W-1:0]     next_beat, next_beat_inc;
  logic                  div_clear, div_load, div_en, div_tc;
  logic [DIV_WIDTH-1:0]  div_load_val;
  logic                  advance, fire;

  assign load_clamped = (period_in < DIV_WIDTH'(MIN_PERIOD)) ? DIV_WIDTH'(MIN_PERIOD) : period_in;
  // A load coinciding with a reload is used by that reload.
  assign pending_eff  = period_load ? load_clamped : pending_period;
  assign next_beat_inc = (next_beat == BEAT_W'(BEATS_PER_BAR - 1)) ? '0 : next_beat + BEAT_W'(1);

  rate_divider #(
    .WIDTH (DIV_WIDTH)
  ) u_div (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (div_clear),
    .load       (div_load),
    .load_value (div_load_val),
    .enable     (div_en),
    .tc         (div_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The resume edge out of PAUSE counts as a RUN cycle, so a countdown that
  // was frozen at zero fires its tick on that very edge.
  always_comb begin
    next_state   = state;
    div_clear    = 1'b0;
    div_load     = 1'b0;
    div_load_val = '0;
    div_en       = 1'b0;
    advance      = 1'b0;
    fire         = 1'b0;
    if (stop) begin
      next_state = IDLE;
      div_clear  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state   = RUN;
            div_load     = 1'b1;
            div_load_val = active_period - DIV_WIDTH'(1);
          end
        end
        RUN: begin
          if (pause) begin
            next_state = PAUSE;
          end else begin
            advance = 1'b1;
          end
        end
        PAUSE: begin
          if (!pause && start) begin
            next_state = RUN;
            advance    = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
          div_clear  = 1'b1;
        end
      endcase
    end
    if (advance) begin
      if (div_tc) begin
        fire         = 1'b1;
        div_load     = 1'b1;
        div_load_val = pending_eff - DIV_WIDTH'(1);
      end else begin
        div_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick           <= 1'b0;
      downbeat       <= 1'b0;
      running        <= 1'b0;
      period_ack     <= 1'b0;
      beat_idx       <= '0;
      next_beat      <= '0;
      active_period  <= DIV_WIDTH'(DEFAULT_PERIOD);
      pending_period <= DIV_WIDTH'(DEFAULT_PERIOD);
    end else begin
      tick       <= fire;
      downbeat   <= fire && (next_beat == '0);
      running    <= (next_state == RUN);
      period_ack <= period_load;
      if (period_load) begin
        pending_period <= load_clamped;
      end
      if (stop) begin
        beat_idx  <= '0;
        next_beat <= '0;
      end else if (state == IDLE) begin
        // While idle, keep the start value in step with the latest load.
        next_beat <= '0;
        if (!start) begin
          active_period <= pending_eff;
        end
      end else if (fire) begin
        beat_idx      <= next_beat;
        next_beat     <= next_beat_inc;
        active_period <= pending_eff;
      end
    end
  end

endmodule
